// File: rtl/route_32_bit.sv
// One-to-two word router. Each destination has its own registered output slot
// with a valid/ready handshake and a wrapping delivery counter for debug.
module route_32_bit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 control,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     result_one,
  output logic                 one_valid,
  input  logic                 one_ready,
  output logic [WIDTH-1:0]     result_two,
  output logic                 two_valid,
  input  logic                 two_ready,
  output logic [CNT_WIDTH-1:0] count_one,
  output logic [CNT_WIDTH-1:0] count_two
);

  logic slot_one_free, slot_two_free;
  logic accept_one, accept_two;
  logic deliver_one, deliver_two;

  // A slot is free when empty or being drained this cycle, which is what
  // allows one word per cycle per destination.
  assign slot_one_free = !one_valid || one_ready;
  assign slot_two_free = !two_valid || two_ready;
  assign in_ready      = control ? slot_two_free : slot_one_free;

  assign accept_one  = in_valid && !control && slot_one_free;
  assign accept_two  = in_valid &&  control && slot_two_free;
  assign deliver_one = one_valid && one_ready;
  assign deliver_two = two_valid && two_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_one <= '0;
      result_two <= '0;
      one_valid  <= 1'b0;
      two_valid  <= 1'b0;
      count_one  <= '0;
      count_two  <= '0;
    end else begin
      if (accept_one) begin
        result_one <= data_in;
        one_valid  <= 1'b1;
      end else if (deliver_one) begin
        one_valid  <= 1'b0;
      end

      if (accept_two) begin
        result_two <= data_in;
        two_valid  <= 1'b1;
      end else if (deliver_two) begin
        two_valid  <= 1'b0;
      end

      if (deliver_one) count_one <= count_one + CNT_WIDTH'(1);
      if (deliver_two) count_two <= count_two + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_route_32_bit.sv
// Scoreboard bench for route_32_bit: a default-width instance and a 4-bit
// counter instance share stimulus; expected words are queued on accept.
module tb_route_32_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        control, in_valid, one_ready, two_ready;

  logic        in_ready, one_valid, two_valid;
  logic [31:0] result_one, result_two;
  logic [15:0] count_one, count_two;

  logic        in_ready_4, one_valid_4, two_valid_4;
  logic [31:0] result_one_4, result_two_4;
  logic [3:0]  count_one_4, count_two_4;

  always #5 clk = ~clk;

  route_32_bit dut (
    .clk(clk), .rst(rst), .data_in(data_in), .control(control),
    .in_valid(in_valid), .in_ready(in_ready),
    .result_one(result_one), .one_valid(one_valid), .one_ready(one_ready),
    .result_two(result_two), .two_valid(two_valid), .two_ready(two_ready),
    .count_one(count_one), .count_two(count_two)
  );

  route_32_bit #(.WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .control(control),
    .in_valid(in_valid), .in_ready(in_ready_4),
    .result_one(result_one_4), .one_valid(one_valid_4), .one_ready(one_ready),
    .result_two(result_two_4), .two_valid(two_valid_4), .two_ready(two_ready),
    .count_one(count_one_4), .count_two(count_two_4)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q_one[$];
  logic [31:0] q_two[$];

  // Reference model state.
  logic        m_v1 = 1'b0, m_v2 = 1'b0;
  logic [31:0] m_r1 = '0, m_r2 = '0;
  int          m_c1 = 0, m_c2 = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: compare DUT outputs against the model, score deliveries,
  // queue accepted words, then advance the model across the rising edge.
  task automatic tick();
    logic free1, free2, exp_ready, acc, d1, d2;
    logic [31:0] exp_word;
    #1;
    free1     = !m_v1 || one_ready;
    free2     = !m_v2 || two_ready;
    exp_ready = control ? free2 : free1;
    if (!rst) begin
      check("in_ready", in_ready, exp_ready);
      check("in_ready_4", in_ready_4, exp_ready);
    end
    check("one_valid", one_valid, m_v1);
    check("two_valid", two_valid, m_v2);
    check("result_one_hold", result_one, m_r1);
    check("result_two_hold", result_two, m_r2);
    check("count_one", count_one, 64'(m_c1 % 65536));
    check("count_two", count_two, 64'(m_c2 % 65536));
    check("count_one_4", count_one_4, 64'(m_c1 % 16));
    check("count_two_4", count_two_4, 64'(m_c2 % 16));

    acc = !rst && in_valid && exp_ready;
    d1  = !rst && m_v1 && one_ready;
    d2  = !rst && m_v2 && two_ready;
    if (d1) begin
      if (q_one.size() == 0) check("q_one_underflow", 64'(q_one.size()), 64'd1);
      else begin exp_word = q_one.pop_front(); check("deliver_one", result_one, exp_word); end
    end
    if (d2) begin
      if (q_two.size() == 0) check("q_two_underflow", 64'(q_two.size()), 64'd1);
      else begin exp_word = q_two.pop_front(); check("deliver_two", result_two, exp_word); end
    end
    if (acc) begin
      if (control) q_two.push_back(data_in);
      else         q_one.push_back(data_in);
    end

    @(posedge clk);
    if (rst) begin
      m_v1 = 1'b0; m_v2 = 1'b0; m_r1 = '0; m_r2 = '0; m_c1 = 0; m_c2 = 0;
      q_one.delete(); q_two.delete();
    end else begin
      if (d1) m_c1++;
      if (d2) m_c2++;
      if (acc && !control)  begin m_r1 = data_in; m_v1 = 1'b1; end
      else if (d1)          m_v1 = 1'b0;
      if (acc && control)   begin m_r2 = data_in; m_v2 = 1'b1; end
      else if (d2)          m_v2 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic ctl, input logic [31:0] word);
    in_valid = 1'b1; control = ctl; data_in = word;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset while a word is offered: first edge has no model to compare yet.
    rst = 1'b1; in_valid = 1'b1; control = 1'b0; data_in = 32'hFFFF_FFFF;
    one_ready = 1'b0; two_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_one_valid", one_valid, 1'b0);
    check("rst_result_one", result_one, 32'h0);
    check("rst_count_one", count_one, 16'h0);
    idle(1);

    // Single route with 1-cycle latency.
    one_ready = 1'b1;
    send(1'b0, 32'h1234_5678);
    #1;
    check("single_one_valid", one_valid, 1'b1);
    check("single_result_one", result_one, 32'h1234_5678);
    check("single_two_valid", two_valid, 1'b0);
    idle(2);
    check("single_count_one", count_one, 16'd1);

    // Backpressure on one must not block two.
    do_reset();
    one_ready = 1'b0; two_ready = 1'b1;
    send(1'b0, 32'hA);
    control = 1'b0;
    #1 check("bp_in_ready_one", in_ready, 1'b0);
    idle(1);
    send(1'b1, 32'hB);
    send(1'b1, 32'hC);
    idle(3);
    check("bp_count_two", count_two, 16'd2);
    check("bp_count_one", count_one, 16'd0);
    check("bp_result_one", result_one, 32'hA);
    one_ready = 1'b1;
    idle(2);

    // Back-to-back alternating stream.
    do_reset();
    one_ready = 1'b1; two_ready = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      in_valid = 1'b1; control = (w % 2 == 0); data_in = 32'(w);
      #1 check("stream_in_ready", in_ready, 1'b1);
      tick();
    end
    idle(2);
    check("stream_count_one", count_one, 16'd4);
    check("stream_count_two", count_two, 16'd4);

    // Counter wrap on the 4-bit instance.
    do_reset();
    two_ready = 1'b1;
    for (int w = 0; w < 17; w++) send(1'b1, 32'h100 + 32'(w));
    idle(2);
    check("wrap_count_two_4", count_two_4, 4'd1);
    check("wrap_count_two", count_two, 16'd17);

    // Reset while a word is held and stalled.
    do_reset();
    one_ready = 1'b0;
    send(1'b0, 32'hDEAD_BEEF);
    #1 check("midrst_held", one_valid, 1'b1);
    do_reset();
    #1;
    check("midrst_one_valid", one_valid, 1'b0);
    check("midrst_count_one", count_one, 16'd0);
    one_ready = 1'b1;
    send(1'b0, 32'h0BAD_F00D);
    #1 check("midrst_new_word", result_one, 32'h0BAD_F00D);
    idle(2);
    check("midrst_new_count", count_one, 16'd1);

    check("q_one_drained", 64'(q_one.size()), 64'd0);
    check("q_two_drained", 64'(q_two.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
